// File: rtl/antares_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : antares_fetch_unit                                               |
// | Brief   : Single-outstanding instruction fetch with a one-entry output     |
// |           buffer, delayed-branch and exception redirects.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module antares_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        id_take_branch,
    input  logic [31:0] pc_branch_address,
    input  logic        exc_redirect,
    input  logic [31:0] exc_address,
    output logic        imem_request,
    output logic [31:0] imem_address,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_add4
);

    localparam logic [0:0]  c_IDLE    = 1'b0;
    localparam logic [0:0]  c_BUSY    = 1'b1;
    localparam logic [31:0] c_PC_STEP = 32'd4;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_br_saved;
    logic [31:0] r_exc_saved;
    logic [31:0] w_next_pc;
    logic        r_drop;
    logic        r_br_pending;
    logic        r_exc_pending;
    logic        w_consume;
    logic        w_take;
    logic        w_issue;
    logic        w_response;
    logic        w_fill;

    assign w_consume  = if_valid & ~id_stall;
    assign w_take     = id_take_branch & ~id_stall;
    // A response racing an exception pulse, or one already marked stale, never reaches decode.
    assign w_fill     = w_response & ~r_drop & ~exc_redirect;
    assign if_pc_add4 = if_pc + c_PC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_response   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!if_valid || w_consume) begin
                    w_issue      = 1'b1;
                    w_state_next = c_BUSY;
                end
            end
            c_BUSY: begin
                if (imem_ready) begin
                    w_response   = 1'b1;
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_next_pc = r_pc + c_PC_STEP;
        if (exc_redirect) begin
            w_next_pc = exc_address;
        end else if (r_exc_pending) begin
            w_next_pc = r_exc_saved;
        end else if (w_take) begin
            w_next_pc = pc_branch_address;
        end else if (r_br_pending) begin
            w_next_pc = r_br_saved;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_request   <= 1'b0;
            imem_address   <= '0;
            if_valid       <= 1'b0;
            if_instruction <= '0;
            if_pc          <= '0;
            r_pc           <= RESET_VECTOR - c_PC_STEP;
            r_drop         <= 1'b0;
            r_br_pending   <= 1'b0;
            r_br_saved     <= '0;
            r_exc_pending  <= 1'b0;
            r_exc_saved    <= '0;
        end else begin
            if (w_issue) begin
                imem_request <= 1'b1;
                imem_address <= w_next_pc;
                r_pc         <= w_next_pc;
            end else if (w_response) begin
                imem_request <= 1'b0;
            end

            if (w_fill) begin
                if_instruction <= imem_data;
                if_pc          <= r_pc;
                if_valid       <= 1'b1;
            end else if (exc_redirect || w_consume) begin
                if_valid <= 1'b0;
            end

            // The request cannot be withdrawn, so an exception mid-flight marks its reply stale.
            if (w_response) begin
                r_drop <= 1'b0;
            end else if (exc_redirect && (r_state == c_BUSY)) begin
                r_drop <= 1'b1;
            end

            // The delay slot is already fetched or in flight, so a taken branch only defers the target.
            if (exc_redirect || w_issue) begin
                r_br_pending <= 1'b0;
            end else if (w_take) begin
                r_br_pending <= 1'b1;
                r_br_saved   <= pc_branch_address;
            end

            if (w_issue) begin
                r_exc_pending <= 1'b0;
            end else if (exc_redirect) begin
                r_exc_pending <= 1'b1;
                r_exc_saved   <= exc_address;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_antares_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_antares_fetch_unit                                            |
// | Brief   : Scoreboard bench for antares_fetch_unit with a latency-          |
// |           programmable instruction memory and a decode-side driver.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_antares_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_stall;
    logic        id_take_branch;
    logic [31:0] pc_branch_address;
    logic        exc_redirect;
    logic [31:0] exc_address;
    logic        imem_request;
    logic [31:0] imem_address;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_add4;

    int          n_checks   = 0;
    int          n_fails    = 0;
    int          cons_count = 0;
    int          cyc        = 0;
    int          mem_lat    = 0;
    bit          force_ready = 1'b0;
    logic [31:0] exp_req_q[$];
    logic [31:0] exp_pc_q[$];

    antares_fetch_unit #(
        .RESET_VECTOR(32'hBFC0_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_stall         (id_stall),
        .id_take_branch   (id_take_branch),
        .pc_branch_address(pc_branch_address),
        .exc_redirect     (exc_redirect),
        .exc_address      (exc_address),
        .imem_request     (imem_request),
        .imem_address     (imem_address),
        .imem_ready       (imem_ready),
        .imem_data        (imem_data),
        .if_valid         (if_valid),
        .if_instruction   (if_instruction),
        .if_pc            (if_pc),
        .if_pc_add4       (if_pc_add4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cons(input int target);
        for (int i = 0; i < 60; i++) begin
            if (cons_count >= target) break;
            step();
        end
        if (cons_count < target) check_eq("wait_cons_timeout", 32'(cons_count), 32'(target));
    endtask

    task automatic check_buf(input logic [31:0] pc);
        check_eq("buf_valid", {31'd0, if_valid}, 32'd1);
        check_eq("buf_pc", if_pc, pc);
        check_eq("buf_pc_add4", if_pc_add4, pc + 32'd4);
        check_eq("buf_instr", if_instruction, memf(pc));
    endtask

    task automatic check_reset_state();
        check_eq("rst_req", {31'd0, imem_request}, 32'd0);
        check_eq("rst_addr", imem_address, 32'd0);
        check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
        check_eq("rst_instr", if_instruction, 32'd0);
        check_eq("rst_pc", if_pc, 32'd0);
        check_eq("rst_pc_add4", if_pc_add4, 32'd4);
    endtask

    // Redirect via exception from a full, stalled, idle buffer; lands with target buffered.
    task automatic jump(input logic [31:0] a);
        exp_req_q.push_back(a);
        exc_address  = a;
        exc_redirect = 1'b1;
        step();
        exc_redirect = 1'b0;
        repeat (4) step();
    endtask

    // Instruction memory: answers after mem_lat cycles of a visible request.
    initial begin : mem_model
        int cnt;
        cnt        = 0;
        imem_ready = 1'b0;
        imem_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            imem_ready = 1'b0;
            imem_data  = '0;
            if (force_ready) begin
                imem_ready = 1'b1;
                imem_data  = 32'hDEAD_BEEF;
            end else if (imem_request) begin
                if (cnt >= mem_lat) begin
                    imem_ready = 1'b1;
                    imem_data  = memf(imem_address);
                    cnt        = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Scoreboard: new requests and decode consumptions are matched against queued expectations.
    initial begin : monitor
        logic        prev_req;
        logic [31:0] e;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_request === 1'b1 && !prev_req) begin
                check_eq("req_expected", (exp_req_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_req_q.size() != 0) begin
                    e = exp_req_q.pop_front();
                    check_eq("req_addr", imem_address, e);
                end
            end
            prev_req = (imem_request === 1'b1);
            if (if_valid === 1'b1 && !id_stall) begin
                check_eq("cons_expected", (exp_pc_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_pc_q.size() != 0) begin
                    e = exp_pc_q.pop_front();
                    check_eq("cons_pc", if_pc, e);
                    check_eq("cons_instr", if_instruction, memf(e));
                    check_eq("cons_pc_add4", if_pc_add4, e + 32'd4);
                end
                cons_count++;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stimulus
        int base;
        int t1;
        int t3;
        rst               = 1'b1;
        id_stall          = 1'b1;
        id_take_branch    = 1'b0;
        pc_branch_address = '0;
        exc_redirect      = 1'b0;
        exc_address       = '0;
        repeat (3) step();
        check_reset_state();

        // Reset release: first fetch at the vector, then sequential stream at 2 cycles each.
        exp_req_q.push_back(32'hBFC0_0000);
        rst = 1'b0;
        repeat (3) step();
        check_buf(32'hBFC0_0000);
        exp_pc_q.push_back(32'hBFC0_0000);
        exp_pc_q.push_back(32'hBFC0_0004);
        exp_pc_q.push_back(32'hBFC0_0008);
        exp_req_q.push_back(32'hBFC0_0004);
        exp_req_q.push_back(32'hBFC0_0008);
        exp_req_q.push_back(32'hBFC0_000C);
        base     = cons_count;
        t1       = -1;
        t3       = -1;
        id_stall = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (cons_count == base + 1 && t1 < 0) t1 = cyc;
            if (cons_count >= base + 3) begin
                t3 = cyc;
                break;
            end
        end
        id_stall = 1'b1;
        check_eq("throughput_cycles", 32'(t3 - t1), 32'd4);

        // Stall with a full buffer: no new request, data held; resumes right after release.
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("stall_no_req", {31'd0, imem_request}, 32'd0);
            check_eq("stall_instr", if_instruction, memf(32'hBFC0_000C));
        end
        exp_pc_q.push_back(32'hBFC0_000C);
        exp_req_q.push_back(32'hBFC0_0010);
        id_stall = 1'b0;
        step();
        id_stall = 1'b1;
        check_eq("resume_req", {31'd0, imem_request}, 32'd1);
        check_eq("resume_addr", imem_address, 32'hBFC0_0010);
        repeat (2) step();

        // Branch at 0x100 taken while the delay slot is in flight.
        jump(32'h0000_0100);
        exp_pc_q.push_back(32'h0000_0100);
        exp_pc_q.push_back(32'h0000_0104);
        exp_pc_q.push_back(32'h0000_0200);
        exp_req_q.push_back(32'h0000_0104);
        exp_req_q.push_back(32'h0000_0200);
        exp_req_q.push_back(32'h0000_0204);
        base     = cons_count;
        id_stall = 1'b0;
        wait_cons(base + 1);
        id_take_branch    = 1'b1;
        pc_branch_address = 32'h0000_0200;
        step();
        id_take_branch = 1'b0;
        wait_cons(base + 3);
        id_stall = 1'b1;
        repeat (2) step();

        // Branch at 0x100 taken while the delay slot sits buffered with the FSM idle.
        jump(32'h0000_0100);
        exp_pc_q.push_back(32'h0000_0100);
        exp_pc_q.push_back(32'h0000_0104);
        exp_pc_q.push_back(32'h0000_0200);
        exp_req_q.push_back(32'h0000_0104);
        exp_req_q.push_back(32'h0000_0200);
        exp_req_q.push_back(32'h0000_0204);
        base     = cons_count;
        id_stall = 1'b0;
        wait_cons(base + 1);
        id_stall          = 1'b1;
        id_take_branch    = 1'b1;
        pc_branch_address = 32'h0000_0200;
        repeat (2) step();
        id_stall = 1'b0;
        step();
        id_take_branch = 1'b0;
        wait_cons(base + 3);
        id_stall = 1'b1;
        repeat (2) step();

        // Exception while a slow fetch of 0x10 is outstanding.
        mem_lat = 3;
        exp_req_q.push_back(32'h0000_0010);
        exp_req_q.push_back(32'h8000_0180);
        exc_address  = 32'h0000_0010;
        exc_redirect = 1'b1;
        step();
        exc_redirect = 1'b0;
        repeat (2) step();
        exc_address  = 32'h8000_0180;
        exc_redirect = 1'b1;
        step();
        exc_redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!imem_request) break;
            check_eq("exc_hold_addr", imem_address, 32'h0000_0010);
            check_eq("exc_hold_valid", {31'd0, if_valid}, 32'd0);
            step();
        end
        mem_lat = 0;
        check_eq("exc_req_done", {31'd0, imem_request}, 32'd0);
        check_eq("exc_discard", {31'd0, if_valid}, 32'd0);
        step();
        check_eq("exc_next_req", {31'd0, imem_request}, 32'd1);
        check_eq("exc_next_addr", imem_address, 32'h8000_0180);
        repeat (2) step();
        check_buf(32'h8000_0180);

        // Exception and taken branch together, also coinciding with the memory response.
        exp_pc_q.push_back(32'h8000_0180);
        exp_req_q.push_back(32'h8000_0184);
        exp_req_q.push_back(32'h0000_0400);
        base     = cons_count;
        id_stall = 1'b0;
        wait_cons(base + 1);
        id_take_branch    = 1'b1;
        pc_branch_address = 32'h0000_0300;
        exc_address       = 32'h0000_0400;
        exc_redirect      = 1'b1;
        step();
        id_take_branch = 1'b0;
        exc_redirect   = 1'b0;
        id_stall       = 1'b1;
        check_eq("exc_ready_discard", {31'd0, if_valid}, 32'd0);
        repeat (3) step();
        check_buf(32'h0000_0400);
        repeat (2) step();
        check_eq("exc_settled_no_req", {31'd0, imem_request}, 32'd0);

        // PC wrap, then reset while a request is outstanding and a stray ready right after.
        jump(32'hFFFF_FFFC);
        check_buf(32'hFFFF_FFFC);
        exp_pc_q.push_back(32'hFFFF_FFFC);
        exp_req_q.push_back(32'h0000_0000);
        mem_lat  = 5;
        base     = cons_count;
        id_stall = 1'b0;
        wait_cons(base + 1);
        id_stall = 1'b1;
        check_eq("wrap_req", {31'd0, imem_request}, 32'd1);
        check_eq("wrap_addr", imem_address, 32'h0000_0000);
        rst = 1'b1;
        step();
        check_reset_state();
        force_ready = 1'b1;
        rst         = 1'b0;
        exp_req_q.push_back(32'hBFC0_0000);
        step();
        force_ready = 1'b0;
        mem_lat     = 0;
        check_eq("late_ready_valid", {31'd0, if_valid}, 32'd0);
        check_eq("post_rst_req", {31'd0, imem_request}, 32'd1);
        check_eq("post_rst_addr", imem_address, 32'hBFC0_0000);
        repeat (3) step();
        check_buf(32'hBFC0_0000);

        repeat (2) step();
        check_eq("req_q_drained", 32'(exp_req_q.size()), 32'd0);
        check_eq("pc_q_drained", 32'(exp_pc_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
